// File: rtl/ub_multitap_delay_line.sv
// Multi-tap delay line: one shared circular buffer, one write pointer, and a
// registered output per tap whose delay is counted in accepted samples.
module ub_multitap_delay_line #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 128,
  parameter int NUM_TAPS = 4,
  parameter logic [16*NUM_TAPS-1:0] TAP_DELAYS = {16'd2, 16'd1, 16'd65, 16'd66}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_en,
  input  logic [WIDTH-1:0]             in_data,
  output logic [WIDTH-1:0]             out_data [NUM_TAPS-1:0],
  output logic [NUM_TAPS-1:0]          out_valid,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FILL_W = $clog2(DEPTH+1);

  function automatic int unsigned tap_delay(input int i);
    return 32'(TAP_DELAYS[16*i +: 16]);
  endfunction

  if (DEPTH < 1 || NUM_TAPS < 1) begin : g_bad_cfg
    $error("ub_multitap_delay_line: DEPTH and NUM_TAPS must be at least 1");
  end

  for (genvar g = 0; g < NUM_TAPS; g++) begin : g_tap_chk
    if (tap_delay(g) < 1 || tap_delay(g) > 32'(DEPTH)) begin : g_bad_delay
      $error("ub_multitap_delay_line: tap delay outside 1..DEPTH");
    end
  end

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q,   wr_ptr_d;
  logic [FILL_W-1:0]   fill_q,     fill_d;
  logic [NUM_TAPS-1:0] valid_q,    valid_d;
  logic [WIDTH-1:0]    out_data_q [NUM_TAPS-1:0];
  logic [WIDTH-1:0]    out_data_d [NUM_TAPS-1:0];

  logic accept;
  assign accept = in_en && !flush;

  // The word written n-D+1 samples ago sits D-1 slots behind wr_ptr; with
  // D <= DEPTH it is never the slot being overwritten on this edge.
  always_comb begin
    int unsigned rd;
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    valid_d    = valid_q;
    out_data_d = out_data_q;
    rd         = 0;
    if (flush) begin
      wr_ptr_d = '0;
      fill_d   = '0;
      valid_d  = '0;
      for (int i = 0; i < NUM_TAPS; i++) out_data_d[i] = '0;
    end else if (in_en) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
      fill_d   = (fill_q == FILL_W'(DEPTH)) ? fill_q : fill_q + 1'b1;
      for (int i = 0; i < NUM_TAPS; i++) begin
        if (32'(fill_q) + 1 >= tap_delay(i)) begin
          rd            = (32'(wr_ptr_q) + 32'(DEPTH) + 1 - tap_delay(i)) % 32'(DEPTH);
          valid_d[i]    = 1'b1;
          out_data_d[i] = (tap_delay(i) == 1) ? in_data : mem_q[rd[PTR_W-1:0]];
        end
      end
    end
  end

  // NOTE: only control/output state is reset; the buffer itself is not, since
  // no output reads a word before the fill count proves it was written.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      valid_q  <= '0;
      for (int i = 0; i < NUM_TAPS; i++) out_data_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      valid_q    <= valid_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = valid_q;
  assign fill_level = fill_q;

endmodule

// File: tb/tb_ub_multitap_delay_line.sv
// Scoreboard bench for ub_multitap_delay_line: default configuration plus a
// DEPTH=4 single-tap variant.
module tb_ub_multitap_delay_line;

  typedef struct packed {
    logic [3:0][15:0] d;
    logic [3:0]       v;
    logic [7:0]       fill;
  } exp_t;

  typedef struct packed {
    logic [15:0] d;
    logic        v;
    logic [2:0]  fill;
  } vexp_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_en;
  logic [15:0] in_data;
  logic [15:0] out_data [3:0];
  logic [3:0]  out_valid;
  logic [7:0]  fill_level;

  logic        v_rst_n, v_flush, v_en;
  logic [15:0] v_data;
  logic [15:0] v_out [0:0];
  logic [0:0]  v_valid;
  logic [2:0]  v_fill;

  int pass_cnt  = 0;
  int total_cnt = 0;

  exp_t        exp_q [$];
  vexp_t       vexp_q [$];
  logic [15:0] hist [$];
  exp_t        cur;
  exp_t        mon_e;
  vexp_t       vmon_e;
  int          delays [4] = '{66, 65, 1, 2};

  always #5 clk = ~clk;

  ub_multitap_delay_line dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_en(in_en), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .fill_level(fill_level)
  );

  ub_multitap_delay_line #(.WIDTH(16), .DEPTH(4), .NUM_TAPS(1), .TAP_DELAYS(16'd4)) dut_v (
    .clk(clk), .rst_n(v_rst_n), .flush(v_flush), .in_en(v_en), .in_data(v_data),
    .out_data(v_out), .out_valid(v_valid), .fill_level(v_fill)
  );

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Ideal reference: tap i after accepting sample n shows sample n-D_i+1.
  task automatic model_update(input logic en, input logic fl, input logic [15:0] d);
    int n;
    if (fl) begin
      hist.delete();
      cur = '0;
    end else if (en) begin
      hist.push_back(d);
      n = hist.size() - 1;
      for (int i = 0; i < 4; i++) begin
        if (n + 1 >= delays[i]) begin
          cur.v[i] = 1'b1;
          cur.d[i] = hist[n - delays[i] + 1];
        end
      end
      cur.fill = (hist.size() > 128) ? 8'd128 : 8'(hist.size());
    end
    exp_q.push_back(cur);
  endtask

  task automatic step(input logic en, input logic fl, input logic [15:0] d);
    in_en = en; flush = fl; in_data = d;
    @(posedge clk);
    #1;
    model_update(en, fl, d);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      for (int i = 0; i < 4; i++) begin
        check($sformatf("tap%0d_data", i), out_data[i], mon_e.d[i]);
        check($sformatf("tap%0d_valid", i), out_valid[i], mon_e.v[i]);
      end
      check("fill_level", fill_level, mon_e.fill);
    end
    if (vexp_q.size() > 0) begin
      vmon_e = vexp_q.pop_front();
      check("var_data", v_out[0], vmon_e.d);
      check("var_valid", v_valid[0], vmon_e.v);
      check("var_fill", v_fill, vmon_e.fill);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_basic_stream;
    for (int v = 1; v <= 40; v++) step(1'b1, 1'b0, 16'(v));
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 16'hDEAD);
    check("hold_fill", fill_level, 40);
    check("hold_tap2", out_data[2], 40);
    step(1'b1, 1'b0, 16'd41);
    check("resume_tap2", out_data[2], 41);
    check("resume_tap3", out_data[3], 40);
    check("resume_tap01_valid", out_valid[1:0], 0);
    for (int v = 42; v <= 70; v++) begin
      step(1'b1, 1'b0, 16'(v));
      if (v == 65) begin
        check("tap1_first_valid", out_valid[1], 1);
        check("tap1_first_data", out_data[1], 1);
        check("tap0_still_invalid", out_valid[0], 0);
      end
      if (v == 66) begin
        check("tap0_first_data", out_data[0], 1);
        check("fill_at_66", fill_level, 66);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_en = 1'b0; in_data = '0;
    v_rst_n = 1'b0; v_flush = 1'b0; v_en = 1'b0; v_data = '0;
    cur = '0;
    #2;
    check("reset_valid", out_valid, 0);
    check("reset_fill", fill_level, 0);
    check("reset_tap0", out_data[0], 0);
    #10;
    rst_n = 1'b1;
    v_rst_n = 1'b1;

    run_basic_stream();
    for (int v = 71; v <= 300; v++) step(1'b1, 1'b0, 16'(v));
    check("saturated_fill", fill_level, 128);
    check("wrap_tap0", out_data[0], 235);
    check("wrap_tap1", out_data[1], 236);

    step(1'b0, 1'b1, 16'd0);
    for (int v = 1; v <= 99; v++) step(1'b1, 1'b0, 16'(v));
    step(1'b1, 1'b1, 16'd100);
    check("flush_fill", fill_level, 0);
    check("flush_valid", out_valid, 0);
    step(1'b1, 1'b0, 16'd7);
    check("post_flush_tap2", out_data[2], 7);
    check("post_flush_tap3_valid", out_valid[3], 0);

    for (int v = 8; v <= 30; v++) step(1'b1, 1'b0, 16'(v));
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_fill", fill_level, 0);
    check("async_rst_tap2", out_data[2], 0);
    #1;
    rst_n = 1'b1;
    hist.delete();
    cur = '0;
    run_basic_stream();
    in_en = 1'b0;

    for (int v = 1; v <= 10; v++) begin
      v_en = 1'b1; v_data = 16'(v);
      @(posedge clk);
      #1;
      vexp_q.push_back('{d: (v >= 4) ? 16'(v - 3) : 16'd0,
                         v: (v >= 4),
                         fill: (v >= 4) ? 3'd4 : 3'(v)});
    end
    v_en = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("queues_drained", exp_q.size() + vexp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
